// File: rtl/sample_recorder_pkg.sv
// Shared constants for the sample recorder.
//   DEFAULT_ADDR_WIDTH : default log2 of the sample buffer depth
//   SAMPLE_WIDTH       : width of codec samples
//   state_t            : recorder FSM state encoding
package sample_recorder_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 12;
  localparam int SAMPLE_WIDTH       = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RECORD   = 2'd1,
    ST_PLAYBACK = 2'd2
  } state_t;

endpackage

// File: rtl/sample_recorder_ram.sv
// sample_ram: single-clock RAM with one write port and one registered read port.
//   clk   : clock
//   we    : write enable, writes wdata to mem[waddr]
//   waddr : write address
//   wdata : write data
//   re    : read enable, captures mem[raddr] into rdata
//   raddr : read address
//   rdata : registered read data, valid the cycle after re
// Contents are never reset so the array maps onto block RAM.
module sample_ram #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sample_recorder.sv
// sample_recorder: records codec frames into a buffer and plays them back.
//   clk                  : system clock
//   reset                : synchronous active-high reset
//   new_frame/adc_sample : incoming codec sample strobe and data
//   record_button        : start/stop a recording take
//   play_button          : start/stop playback of the last take
//   generate_next_sample : request for the next output sample
//   sample_out           : output sample, held between updates
//   new_sample_ready     : pulses one cycle after each request
//   recording/playing    : current FSM state flags
//   buffer_full          : last take ended because the buffer filled
module sample_recorder
  import sample_recorder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_frame,
  input  logic [SAMPLE_WIDTH-1:0] adc_sample,
  input  logic                    record_button,
  input  logic                    play_button,
  input  logic                    generate_next_sample,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    new_sample_ready,
  output logic                    recording,
  output logic                    playing,
  output logic                    buffer_full
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_FULL  = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   wr_addr_reg, wr_addr_next;
  logic [ADDR_WIDTH-1:0]   rd_addr_reg, rd_addr_next;
  logic [ADDR_WIDTH:0]     length_reg, length_next;
  logic                    full_reg, full_next;
  logic                    ready_reg;
  logic                    from_ram_reg, from_ram_next;
  logic [SAMPLE_WIDTH-1:0] hold_reg;

  logic                    ram_we;
  logic                    ram_re;
  logic [SAMPLE_WIDTH-1:0] ram_rdata;
  logic                    last_write;

  sample_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (SAMPLE_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_addr_reg),
    .wdata (adc_sample),
    .re    (ram_re),
    .raddr (rd_addr_reg),
    .rdata (ram_rdata)
  );

  assign last_write = new_frame && (wr_addr_reg == LAST_ADDR);

  always_comb begin
    state_next    = state_reg;
    wr_addr_next  = wr_addr_reg;
    rd_addr_next  = rd_addr_reg;
    length_next   = length_reg;
    full_next     = full_reg;
    from_ram_next = 1'b0;
    ram_we        = 1'b0;
    ram_re        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Record has priority over play when both arrive together.
        if (record_button) begin
          state_next   = ST_RECORD;
          wr_addr_next = '0;
          length_next  = '0;
          full_next    = 1'b0;
        end else if (play_button && (length_reg != '0)) begin
          state_next   = ST_PLAYBACK;
          rd_addr_next = '0;
        end
      end

      ST_RECORD: begin
        if (new_frame) begin
          ram_we = 1'b1;
          // The last address is not advanced past so wr_addr never wraps.
          if (!last_write) begin
            wr_addr_next = wr_addr_reg + ADDR_ONE;
          end
        end
        if (last_write) begin
          length_next = LEN_FULL;
          full_next   = 1'b1;
          state_next  = ST_IDLE;
        end else if (record_button) begin
          // Count includes a frame written in this same cycle.
          length_next = {1'b0, wr_addr_reg} + (new_frame ? LEN_ONE : '0);
          state_next  = ST_IDLE;
        end
      end

      ST_PLAYBACK: begin
        if (generate_next_sample) begin
          ram_re        = 1'b1;
          from_ram_next = 1'b1;
          if (({1'b0, rd_addr_reg} + LEN_ONE) == length_reg) begin
            state_next = ST_IDLE;
          end else begin
            rd_addr_next = rd_addr_reg + ADDR_ONE;
          end
        end
        // An issued read is still delivered through from_ram_reg.
        if (play_button) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      wr_addr_reg  <= '0;
      rd_addr_reg  <= '0;
      length_reg   <= '0;
      full_reg     <= 1'b0;
      ready_reg    <= 1'b0;
      from_ram_reg <= 1'b0;
      hold_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      wr_addr_reg  <= wr_addr_next;
      rd_addr_reg  <= rd_addr_next;
      length_reg   <= length_next;
      full_reg     <= full_next;
      ready_reg    <= generate_next_sample;
      from_ram_reg <= from_ram_next;
      if (ready_reg) begin
        hold_reg <= sample_out;
      end
    end
  end

  // The RAM output register supplies the sample directly in the ready
  // cycle, keeping request-to-ready latency at one cycle; afterwards the
  // delivered value is held in hold_reg.
  assign sample_out       = ready_reg ? (from_ram_reg ? ram_rdata : '0) : hold_reg;
  assign new_sample_ready = ready_reg;
  assign recording        = (state_reg == ST_RECORD);
  assign playing          = (state_reg == ST_PLAYBACK);
  assign buffer_full      = full_reg;

endmodule

// File: tb/tb_sample_recorder.sv
// Self-checking bench for sample_recorder with an 8-sample buffer.
// A take-level reference model (sample array, take length, mode flags)
// predicts every output after each driven cycle.
module tb_sample_recorder;

  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_frame;
  logic [15:0] adc_sample;
  logic        record_button;
  logic        play_button;
  logic        generate_next_sample;
  logic [15:0] sample_out;
  logic        new_sample_ready;
  logic        recording;
  logic        playing;
  logic        buffer_full;

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [15:0] m_mem [DEPTH];
  int          m_written;
  int          m_len;
  int          m_idx;
  bit          m_rec;
  bit          m_play;
  bit          m_full;
  logic [15:0] m_out;

  sample_recorder #(.ADDR_WIDTH(AW)) dut (
    .clk                  (clk),
    .reset                (reset),
    .new_frame            (new_frame),
    .adc_sample           (adc_sample),
    .record_button        (record_button),
    .play_button          (play_button),
    .generate_next_sample (generate_next_sample),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready),
    .recording            (recording),
    .playing              (playing),
    .buffer_full          (buffer_full)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(string tag);
    check({tag, ".recording"}, 16'(recording), 16'(m_rec));
    check({tag, ".playing"}, 16'(playing), 16'(m_play));
    check({tag, ".buffer_full"}, 16'(buffer_full), 16'(m_full));
    check({tag, ".ready"}, 16'(new_sample_ready), 16'd0);
    check({tag, ".sample_out"}, sample_out, m_out);
  endtask

  task automatic model_reset();
    m_rec = 0; m_play = 0; m_full = 0; m_len = 0; m_idx = 0;
    m_written = 0; m_out = 16'h0;
  endtask

  task automatic model_write(logic [15:0] val);
    m_mem[m_written] = val;
    m_written++;
    if (m_written == DEPTH) begin
      m_full = 1; m_len = DEPTH; m_rec = 0;
    end
  endtask

  task automatic do_reset(string tag);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_status(tag);
    $display("txn %s: reset", tag);
  endtask

  // One cycle of button / frame activity.
  task automatic press(bit rec, bit ply, bit frm, logic [15:0] val, string tag);
    bit was_rec, was_play;
    record_button = rec; play_button = ply; new_frame = frm; adc_sample = val;
    tick();
    record_button = 0; play_button = 0; new_frame = 0; adc_sample = 16'h0;
    was_rec = m_rec; was_play = m_play;
    if (was_rec) begin
      if (frm) model_write(val);
      if (rec && m_rec) begin
        m_len = m_written; m_rec = 0;
      end
    end else if (was_play) begin
      if (ply) m_play = 0;
    end else begin
      if (rec) begin
        m_rec = 1; m_written = 0; m_len = 0; m_full = 0;
      end else if (ply && m_len > 0) begin
        m_play = 1; m_idx = 0;
      end
    end
    check_status(tag);
    $display("txn %s: rec=%0d play=%0d frame=%0d val=%h -> recording=%0d playing=%0d full=%0d",
             tag, rec, ply, frm, val, recording, playing, buffer_full);
  endtask

  // Request a sample, check the one-cycle response and the following idle cycle.
  task automatic gen(string tag);
    logic [15:0] exp;
    generate_next_sample = 1'b1;
    tick();
    generate_next_sample = 1'b0;
    if (m_play) begin
      exp = m_mem[m_idx];
      m_idx++;
      if (m_idx == m_len) m_play = 0;
    end else begin
      exp = 16'h0;
    end
    m_out = exp;
    check({tag, ".ready"}, 16'(new_sample_ready), 16'd1);
    check({tag, ".sample"}, sample_out, exp);
    check({tag, ".playing"}, 16'(playing), 16'(m_play));
    $display("txn %s: gen -> sample_out=%h ready=%0d playing=%0d", tag, sample_out, new_sample_ready, playing);
    tick();
    check_status({tag, ".after"});
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check_status(tag);
    end
  endtask

  initial begin
    reset = 1'b1; new_frame = 0; adc_sample = 16'h0; record_button = 0;
    play_button = 0; generate_next_sample = 0;
    tick();
    do_reset("reset0");

    // Play with empty buffer is ignored.
    press(0, 1, 0, 16'h0, "play_len0");

    // Five-frame take, then seven requests.
    press(1, 0, 0, 16'h0, "rec5_start");
    for (int i = 1; i <= 5; i++) press(0, 0, 1, 16'(i), "rec5_frame");
    press(1, 0, 0, 16'h0, "rec5_stop");
    press(0, 1, 0, 16'h0, "play5_start");
    for (int i = 0; i < 7; i++) gen("play5_gen");

    // Overfull take: ten frames offered, eight kept.
    press(1, 0, 0, 16'h0, "rec10_start");
    for (int i = 0; i < 10; i++) press(0, 0, 1, 16'h0010 + 16'(i), "rec10_frame");
    press(0, 1, 0, 16'h0, "play8_start");
    for (int i = 0; i < 10; i++) gen("play8_gen");

    // Both buttons in IDLE: record wins. Stop coincides with third frame.
    press(1, 1, 0, 16'h0, "both_buttons");
    gen("gen_in_record");
    press(0, 1, 1, 16'h0031, "play_in_record");
    press(0, 0, 1, 16'h0032, "rec3_frame");
    press(1, 0, 1, 16'h00AA, "rec3_stop_frame");
    press(0, 1, 0, 16'h0, "play3_start");
    press(1, 0, 0, 16'h0, "rec_in_play");
    for (int i = 0; i < 4; i++) gen("play3_gen");

    // Play stop mid-take, then reset during playback.
    press(0, 1, 0, 16'h0, "play3_again");
    gen("play3_stop_gen");
    press(0, 1, 0, 16'h0, "play3_stop");
    press(0, 1, 0, 16'h0, "play3_restart");
    gen("playrst_gen");
    gen("playrst_gen");
    reset = 1'b1; generate_next_sample = 1'b1;
    tick();
    reset = 1'b0; generate_next_sample = 1'b0;
    model_reset();
    check_status("reset_mid_play");
    $display("txn reset_mid_play: outputs ready=%0d sample_out=%h", new_sample_ready, sample_out);
    press(0, 1, 0, 16'h0, "play_after_reset");

    // Randomized takes.
    for (int t = 0; t < 6; t++) begin
      int n;
      bit with_frame;
      n = int'($urandom_range(1, 10));
      with_frame = bit'($urandom_range(0, 1));
      press(1, 0, 0, 16'h0, "rnd_rec_start");
      for (int i = 0; i < n; i++) begin
        press(0, 0, 1, 16'($urandom_range(0, 65535)), "rnd_frame");
        if ($urandom_range(0, 3) == 0) idle(1, "rnd_gap");
      end
      if (m_rec) press(1, 0, with_frame, 16'($urandom_range(0, 65535)), "rnd_rec_stop");
      press(0, 1, 0, 16'h0, "rnd_play_start");
      for (int i = 0; i < m_len + 2; i++) begin
        gen("rnd_gen");
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)), "rnd_gap");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
